// File: rtl/carry_look_ahead_adder_4bit.sv
// Registered 4-bit carry-look-ahead adder: per-bit G/P cells feed a flattened
// look-ahead unit; sum, carry-out and group P/G are registered on clk.

module cla_gp_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_a & i_b;
    assign o_p = i_a ^ i_b;
endmodule

module cla_lookahead_unit (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_c0,
    output logic [4:0] o_c,
    output logic       o_p_grp,
    output logic       o_g_grp
);
    logic w_g_grp;

    // Each carry is a two-level sum of products; no carry feeds another.
    assign o_c[0] = i_c0;
    assign o_c[1] = i_g[0] | (i_p[0] & i_c0);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c0);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c0);

    assign w_g_grp = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                   | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

    assign o_c[4]  = w_g_grp | (&i_p & i_c0);
    assign o_p_grp = &i_p;
    assign o_g_grp = w_g_grp;
endmodule

module carry_look_ahead_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             P_grp,
    output logic             G_grp
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic       w_p_grp;
    logic       w_g_grp;
    logic [3:0] r_sum;
    logic       r_cout;
    logic       r_p_grp;
    logic       r_g_grp;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        cla_gp_cell u_gp (
            .i_a (A[i]),
            .i_b (B[i]),
            .o_g (w_g[i]),
            .o_p (w_p[i])
        );
    end

    cla_lookahead_unit u_cla (
        .i_g     (w_g),
        .i_p     (w_p),
        .i_c0    (Cin),
        .o_c     (w_c),
        .o_p_grp (w_p_grp),
        .o_g_grp (w_g_grp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= 4'b0000;
            r_cout  <= 1'b0;
            r_p_grp <= 1'b0;
            r_g_grp <= 1'b0;
        end else begin
            r_sum   <= w_p ^ w_c[3:0];
            r_cout  <= w_c[4];
            r_p_grp <= w_p_grp;
            r_g_grp <= w_g_grp;
        end
    end

    assign Sum   = r_sum;
    assign Cout  = r_cout;
    assign P_grp = r_p_grp;
    assign G_grp = r_g_grp;
endmodule

// File: tb/tb_carry_look_ahead_adder_4bit.sv
// Scoreboard bench for carry_look_ahead_adder_4bit: stimulus queues the
// expected {G_grp, P_grp, Cout, Sum}; a monitor compares after every edge.

module tb_carry_look_ahead_adder_4bit;
    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       P_grp;
    logic       G_grp;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];
    string      name_q[$];
    bit         done = 0;

    carry_look_ahead_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
        .P_grp (P_grp),
        .G_grp (G_grp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge so the next rising edge samples it.
    task automatic apply(input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [6:0] exp, input string nm);
        @(negedge clk);
        rst = r; A = a; B = b; Cin = c;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    function automatic logic [6:0] model(input logic r, input logic [3:0] a,
                                         input logic [3:0] b, input logic c);
        logic [4:0] full;
        logic [4:0] nocin;
        full  = {1'b0, a} + {1'b0, b} + {4'b0, c};
        nocin = {1'b0, a} + {1'b0, b};
        if (r) return 7'b0;
        return {nocin[4], &(a ^ b), full};
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            logic [6:0] got;
            string nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {G_grp, P_grp, Cout, Sum};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got G=%b P=%b C=%b S=%b, want G=%b P=%b C=%b S=%b",
                         nm, got[6], got[5], got[4], got[3:0], e[6], e[5], e[4], e[3:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; A = 4'b0; B = 4'b0; Cin = 1'b0;
        // Directed vectors; expected fields are {G_grp, P_grp, Cout, Sum}.
        apply(1, 4'b1111, 4'b1111, 1, 7'b0_0_0_0000, "reset0");
        apply(1, 4'b1111, 4'b1111, 1, 7'b0_0_0_0000, "reset1");
        apply(0, 4'b1111, 4'b1111, 1, 7'b1_0_1_1111, "release");
        apply(0, 4'b1011, 4'b1101, 0, 7'b1_0_1_1000, "carry_out");
        apply(0, 4'b0101, 4'b0011, 0, 7'b0_0_0_1000, "no_carry");
        apply(0, 4'b1001, 4'b0110, 1, 7'b0_1_1_0000, "propagate_cin");
        apply(0, 4'b1111, 4'b1111, 0, 7'b1_0_1_1110, "all_ones");
        apply(0, 4'b0000, 4'b0000, 0, 7'b0_0_0_0000, "all_zero");
        apply(0, 4'b1010, 4'b0101, 1, 7'b0_1_1_0000, "full_chain");
        apply(0, 4'b0000, 4'b0000, 1, 7'b0_0_0_0001, "cin_only");
        apply(1, 4'b1010, 4'b0101, 1, 7'b0_0_0_0000, "reset_mid");

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic       r;
            v = i[8:0];
            r = (i == 256);
            apply(r, v[8:5], v[4:1], v[0], model(r, v[8:5], v[4:1], v[0]),
                  r ? "sweep_reset" : "sweep");
        end
        apply(0, 4'b0111, 4'b0001, 0, 7'b0_0_0_1000, "after_sweep");

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        done = 1;
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not finish, want completion");
            $fatal(1, "timeout");
        end
    end
endmodule
